// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM geometry and arbiter grant encoding
//
// Purpose: constants and types shared by the SRAM access front end.
//   SRAM_ADDR_W       controller address width
//   SRAM_DATA_W       controller data word width
//   SRAM_READ_LATENCY cycles from the controller latching a read to stable data_out
//   grant_e           command chosen by the arbiter for the next cycle
package sram_pkg;

  localparam int SRAM_ADDR_W       = 20;
  localparam int SRAM_DATA_W       = 17;
  localparam int SRAM_READ_LATENCY = 4;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_READ  = 2'd1,
    GRANT_WRITE = 2'd2
  } grant_e;

endpackage

// File: rtl/sram_wr_fifo.sv
// rtl/sram_wr_fifo.sv - synchronous write buffer with registered count
//
// Purpose: holds {addr, data} write words until the arbiter issues them.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (empties the buffer)
//   push        store push_data (ignored while full, even if popping)
//   push_data   word to store
//   pop         drop the head word (ignored while empty)
//   head        oldest stored word
//   full, empty flags decoded from the registered count
module sram_wr_fifo
  import sram_pkg::*;
#(
  parameter int WIDTH = SRAM_ADDR_W + SRAM_DATA_W,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - read-priority SRAM command arbiter with tagged read return
//
// Purpose: merges a buffered write stream and a read stream into one registered
// SRAM command per clock; reads win unless a write has waited MAX_READ_RUN grants.
// Read data is returned after a fixed latency tracked by a tag shift register.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data  write stream into the buffer
//   rd_req_valid/rd_req_ready/rd_req_addr  read request stream
//   rd_resp_valid/rd_resp_data         one-cycle read return strobe and data
//   sram_write_enable/sram_addr/sram_data_in  registered command to the controller
//   sram_data_out                      read data from the controller
module sram_access_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int READ_LATENCY  = SRAM_READ_LATENCY,
  parameter int WR_FIFO_DEPTH = 8,
  parameter int MAX_READ_RUN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out
);

  localparam int RUN_W = $clog2(MAX_READ_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_READ_RUN);

  logic                     rst_q;
  logic [RUN_W-1:0]         run_cnt;
  logic [READ_LATENCY:0]    tag_pipe;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     write_pending;
  logic                     force_write;
  logic                     push;
  logic                     pop;
  grant_e                   grant;

  sram_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // rst_q keeps wr_ready low on the first edge in reset and the edge that releases it.
  assign wr_ready      = rst_q & ~fifo_full;
  assign push          = wr_valid & wr_ready;
  assign write_pending = ~fifo_empty;
  assign force_write   = write_pending & (run_cnt == RUN_MAX);
  assign rd_req_ready  = ~force_write;
  assign pop           = (grant == GRANT_WRITE);

  always_comb begin
    grant = GRANT_IDLE;
    if (rd_req_valid && !force_write) begin
      grant = GRANT_READ;
    end else if (write_pending) begin
      grant = GRANT_WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_q             <= 1'b0;
      run_cnt           <= '0;
      tag_pipe          <= '0;
      sram_write_enable <= 1'b0;
      sram_addr         <= '0;
      sram_data_in      <= '0;
      rd_resp_valid     <= 1'b0;
      rd_resp_data      <= '0;
    end else begin
      rst_q    <= 1'b1;
      // One bit per issued command; only real reads are tagged, so idle
      // dummy reads never produce a response.
      tag_pipe <= {tag_pipe[READ_LATENCY-1:0], grant == GRANT_READ};

      case (grant)
        GRANT_READ: begin
          sram_write_enable <= 1'b0;
          sram_addr         <= rd_req_addr;
          // Only reads that overtake a waiting write count toward starvation.
          if (!write_pending)          run_cnt <= '0;
          else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
        end
        GRANT_WRITE: begin
          sram_write_enable <= 1'b1;
          sram_addr         <= fifo_head[ADDR_W+DATA_W-1:DATA_W];
          sram_data_in      <= fifo_head[DATA_W-1:0];
          run_cnt           <= '0;
        end
        default: begin
          sram_write_enable <= 1'b0;
          sram_addr         <= '0;
          run_cnt           <= '0;
        end
      endcase

      rd_resp_valid <= tag_pipe[READ_LATENCY];
      if (tag_pipe[READ_LATENCY]) begin
        rd_resp_data <= sram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - randomized bench for sram_access_arbiter against a queue-based reference
module tb_sram_access_arbiter;
  import sram_pkg::*;

  localparam int AW     = SRAM_ADDR_W;
  localparam int DW     = SRAM_DATA_W;
  localparam int RL     = SRAM_READ_LATENCY;
  localparam int DEPTH  = 8;
  localparam int MAXRUN = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_resp_valid;
  logic [DW-1:0] rd_resp_data;
  logic          sram_write_enable;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_in;
  logic [DW-1:0] sram_data_out;

  always #5 clk = ~clk;

  sram_access_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .READ_LATENCY  (RL),
    .WR_FIFO_DEPTH (DEPTH),
    .MAX_READ_RUN  (MAXRUN)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .rd_req_valid      (rd_req_valid),
    .rd_req_ready      (rd_req_ready),
    .rd_req_addr       (rd_req_addr),
    .rd_resp_valid     (rd_resp_valid),
    .rd_resp_data      (rd_resp_data),
    .sram_write_enable (sram_write_enable),
    .sram_addr         (sram_addr),
    .sram_data_in      (sram_data_in),
    .sram_data_out     (sram_data_out)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: write buffer as a queue, outstanding responses as a queue of
  // (due cycle, data), and the SRAM itself as a sparse memory with a data
  // delay line of RL entries.
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int due; logic [DW-1:0] data; } resp_t;

  wr_t           wq[$];
  resp_t         rq[$];
  logic [DW-1:0] dline[$];
  logic [DW-1:0] mem [int];
  int            streak;      // reads granted back to back while a write waited
  bit            rst_m;       // rst_n seen at the last edge
  int            cyc;
  bit            exp_we;
  bit            exp_tag;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;
  logic [DW-1:0] last_resp;

  function automatic logic [DW-1:0] rdmem(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[DW-1:0] ^ 17'h0A5A5;
  endfunction

  // Drive one cycle of inputs, advance past the edge and check what the DUT shows.
  task automatic cycle(input bit rst, input bit rv, input logic [AW-1:0] ra,
                       input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       output bit racc, output bit wacc);
    bit            pend;
    bit            exp_rdy;
    bit            exp_wrdy;
    bit            exp_v;
    wr_t           w;
    resp_t         r;
    logic [DW-1:0] v;

    pend     = (wq.size() != 0);
    exp_rdy  = !(pend && streak >= MAXRUN);
    exp_wrdy = rst_m && (wq.size() != DEPTH);
    check_val("rd_req_ready", rd_req_ready, exp_rdy);
    check_val("wr_ready", wr_ready, exp_wrdy);

    rst_n        = !rst;
    rd_req_valid = rv;
    rd_req_addr  = ra;
    wr_valid     = wv;
    wr_addr      = wa;
    wr_data      = wd;
    racc = !rst && rv && exp_rdy;
    wacc = !rst && wv && exp_wrdy;

    if (rst) begin
      wq.delete();
      rq.delete();
      streak    = 0;
      rst_m     = 1'b0;
      exp_we    = 1'b0;
      exp_tag   = 1'b0;
      exp_addr  = '0;
      exp_din   = '0;
      last_resp = '0;
    end else begin
      rst_m   = 1'b1;
      exp_tag = racc;
      if (racc) begin
        exp_we   = 1'b0;
        exp_addr = ra;
        streak   = pend ? streak + 1 : 0;
      end else if (pend) begin
        w        = wq.pop_front();
        exp_we   = 1'b1;
        exp_addr = w.addr;
        exp_din  = w.data;
        streak   = 0;
      end else begin
        exp_we   = 1'b0;
        exp_addr = '0;
        streak   = 0;
      end
      if (wacc) begin
        w.addr = wa;
        w.data = wd;
        wq.push_back(w);
      end
    end

    @(posedge clk);
    #1;
    cyc++;

    check_val("sram_write_enable", sram_write_enable, exp_we);
    check_val("sram_addr", sram_addr, exp_addr);
    check_val("sram_data_in", sram_data_in, exp_din);
    exp_v = (rq.size() != 0) && (rq[0].due == cyc);
    if (exp_v) begin
      r         = rq.pop_front();
      last_resp = r.data;
    end
    check_val("rd_resp_valid", rd_resp_valid, exp_v);
    check_val("rd_resp_data", rd_resp_data, last_resp);

    // SRAM controller: latches this command at the next edge; read data is
    // presented RL cycles after the command appeared. Unused slots carry junk.
    if (exp_we) begin
      mem[int'(exp_addr)] = exp_din;
      dline.push_back(DW'($urandom));
    end else if (exp_tag) begin
      v      = rdmem(exp_addr);
      r.due  = cyc + RL + 1;
      r.data = v;
      rq.push_back(r);
      dline.push_back(v);
    end else begin
      dline.push_back(DW'($urandom));
    end
    sram_data_out = dline.pop_front();
  endtask

  task automatic idle(input int n);
    bit ra_ok;
    bit wa_ok;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, AW'($urandom), 1'b0, AW'($urandom), DW'($urandom), ra_ok, wa_ok);
    end
  endtask

  initial begin
    bit ra_ok;
    bit wa_ok;
    int cnt;
    int prd;
    int pwr;

    rst_n         = 1'b0;
    rd_req_valid  = 1'b1;
    wr_valid      = 1'b1;
    rd_req_addr   = '0;
    wr_addr       = '0;
    wr_data       = '0;
    sram_data_out = '0;
    streak        = 0;
    rst_m         = 1'b0;
    exp_we        = 1'b0;
    exp_tag       = 1'b0;
    exp_addr      = '0;
    exp_din       = '0;
    last_resp     = '0;
    cyc           = 0;
    mem[int'(20'h00ABC)] = 17'h1F00F;
    for (int i = 0; i < RL; i++) dline.push_back(DW'($urandom));
    @(posedge clk);
    #1;

    // Reset held with both streams requesting, then a quiet window.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 20'h00001, 1'b1, 20'h00002, 17'h00003, ra_ok, wa_ok);
    idle(8);

    // Single read of a preloaded word.
    cycle(1'b0, 1'b1, 20'h00ABC, 1'b0, '0, '0, ra_ok, wa_ok);
    check_val("single_read_accepted", ra_ok, 1'b1);
    idle(8);

    // Write fill with the reader idle: nine writes stream straight through.
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 9; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, AW'(cnt + 32), DW'(cnt * 7 + 1), ra_ok, wa_ok);
      if (wa_ok) cnt++;
    end
    check_val("write_fill_pushes", cnt, 9);
    idle(4);

    // Backpressure: continuous reads fill the buffer; the 9th write waits for a pop.
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b1, AW'(i % 16), cnt < 9, AW'(cnt + 64), DW'(cnt * 13 + 5), ra_ok, wa_ok);
      if (wa_ok) cnt++;
    end
    check_val("backpressure_pushes", cnt, 9);
    idle(12);

    // Starvation guard: one write against a continuous read stream.
    cycle(1'b0, 1'b1, 20'h00005, 1'b1, 20'h00099, 17'h0BEEF, ra_ok, wa_ok);
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 1'b1, AW'(i), 1'b0, '0, '0, ra_ok, wa_ok);
      if (ra_ok) cnt++;
    end
    check_val("starve_read_grants", cnt, MAXRUN);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 20'h00099, 1'b0, '0, '0, ra_ok, wa_ok);
    idle(8);

    // Reset with three reads in flight, then one fresh read.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, AW'(i + 1), 1'b0, '0, '0, ra_ok, wa_ok);
    cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, ra_ok, wa_ok);
    cycle(1'b0, 1'b1, 20'h00ABC, 1'b0, '0, '0, ra_ok, wa_ok);
    idle(8);

    // Randomized traffic over a small address window so read/write hazards occur.
    for (int blk = 0; blk < 6; blk++) begin
      case ($urandom_range(0, 3))
        0:       prd = 30;
        1:       prd = 70;
        2:       prd = 95;
        default: prd = 100;
      endcase
      case ($urandom_range(0, 2))
        0:       pwr = 20;
        1:       pwr = 50;
        default: pwr = 90;
      endcase
      for (int i = 0; i < 500; i++) begin
        cycle($urandom_range(0, 299) == 0,
              $urandom_range(0, 99) < prd, AW'($urandom_range(0, 15)),
              $urandom_range(0, 99) < pwr, AW'($urandom_range(0, 15)), DW'($urandom),
              ra_ok, wa_ok);
      end
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
